har_tnn1_tnnzeq: RTL and testbench

- Sequential ternary neural network (TNN) classifier for the HAR (human activity recognition) dataset.
- Takes 12 unsigned 4-bit features and computes a 40-neuron ternary hidden layer with zero-inclusive sign activation, then a 6-class ternary output layer.
- Outputs the argmax class index.
- Processes one feature per cycle, then one hidden neuron per cycle; completes in FEAT_CNT+HIDDEN_CNT cycles after reset release.

---
 rtl/har_tnn1_tnnzeq.sv | 140 ++++++++++++++
 tb/tb_har_tnn1_tnnzeq.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/har_tnn1_tnnzeq.sv
// Sequential ternary-weight classifier for HAR features. It handles one input feature
// per cycle, then one hidden neuron per cycle, and then holds the argmax class.
//
// state  | meaning
// S_FEAT | accumulate feature cnt into every hidden accumulator
// S_HID  | add hidden neuron (cnt-FEAT_CNT) into every class score
// S_DONE | inference complete, accumulators and scores frozen
module har_tnn1_tnnzeq #(
  parameter int FEAT_CNT   = 12,
  parameter int HIDDEN_CNT = 40,
  parameter int FEAT_BITS  = 4,
  parameter int CLASS_CNT  = 6,
  parameter logic [2*HIDDEN_CNT*FEAT_CNT-1:0]  W1 = '0,
  parameter logic [2*CLASS_CNT*HIDDEN_CNT-1:0] W2 = '0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [FEAT_BITS*FEAT_CNT-1:0]    data,
  output logic [$clog2(CLASS_CNT)-1:0]     prediction
);

  localparam int STEPS   = FEAT_CNT + HIDDEN_CNT;
  localparam int CNT_W   = $clog2(STEPS + 1);
  localparam int ACC_W   = $clog2(FEAT_CNT * (2**FEAT_BITS - 1) + 1) + 1;
  localparam int SCORE_W = $clog2(HIDDEN_CNT + 1) + 1;
  localparam int PRED_W  = $clog2(CLASS_CNT);

  localparam logic [CNT_W-1:0] LAST_FEAT = CNT_W'(FEAT_CNT - 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);
  localparam logic [CNT_W-1:0] DONE_CNT  = CNT_W'(STEPS);

  typedef enum logic [1:0] {
    S_FEAT = 2'd0,
    S_HID  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [FEAT_BITS*FEAT_CNT-1:0] feat_sr;
  logic [HIDDEN_CNT-1:0] hid_sr;
  logic [HIDDEN_CNT-1:0] hid_nxt;
  logic signed [ACC_W-1:0]   acc       [HIDDEN_CNT];
  logic signed [ACC_W-1:0]   acc_nxt   [HIDDEN_CNT];
  logic signed [SCORE_W-1:0] score     [CLASS_CNT];
  logic signed [SCORE_W-1:0] score_nxt [CLASS_CNT];
  logic signed [ACC_W-1:0]   x_ext;
  logic signed [SCORE_W-1:0] best_score;
  logic [PRED_W-1:0] best_idx;
  logic feat_en, hid_en, hid_load;
  int k_idx, j_idx;

  always_comb begin
    state_nxt = state;
    feat_en   = 1'b0;
    hid_en    = 1'b0;
    hid_load  = 1'b0;
    case (state)
      S_FEAT: begin
        feat_en = 1'b1;
        if (cnt == LAST_FEAT) begin
          hid_load  = 1'b1;
          state_nxt = S_HID;
        end
      end
      S_HID: begin
        hid_en = 1'b1;
        if (cnt == LAST_STEP) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_DONE;
      default: state_nxt = S_DONE;
    endcase
  end

  // The current feature always sits in the low bits of the shift register.
  always_comb begin
    x_ext = ACC_W'($signed({1'b0, feat_sr[FEAT_BITS-1:0]}));
    k_idx = feat_en ? int'(cnt) : 0;
    for (int h = 0; h < HIDDEN_CNT; h++) begin
      acc_nxt[h] = acc[h];
      case (W1[2*(h*FEAT_CNT+k_idx) +: 2])
        2'b01:   acc_nxt[h] = acc[h] + x_ext;
        2'b11:   acc_nxt[h] = acc[h] - x_ext;
        default: acc_nxt[h] = acc[h];
      endcase
      hid_nxt[h] = ~acc_nxt[h][ACC_W-1];
    end
  end

  // hid_sr[0] is the hidden neuron consumed this step; a 1 means +1, a 0 means -1.
  always_comb begin
    j_idx = hid_en ? (int'(cnt) - FEAT_CNT) : 0;
    for (int c = 0; c < CLASS_CNT; c++) begin
      score_nxt[c] = score[c];
      case (W2[2*(c*HIDDEN_CNT+j_idx) +: 2])
        2'b01:   score_nxt[c] = hid_sr[0] ? score[c] + SCORE_W'(1) : score[c] - SCORE_W'(1);
        2'b11:   score_nxt[c] = hid_sr[0] ? score[c] - SCORE_W'(1) : score[c] + SCORE_W'(1);
        default: score_nxt[c] = score[c];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= S_FEAT;
      cnt     <= '0;
      feat_sr <= data;
      hid_sr  <= '0;
      for (int h = 0; h < HIDDEN_CNT; h++) acc[h] <= '0;
      for (int c = 0; c < CLASS_CNT; c++) score[c] <= '0;
    end else begin
      state <= state_nxt;
      if (cnt != DONE_CNT) cnt <= cnt + 1'b1;
      if (feat_en) begin
        feat_sr <= feat_sr >> FEAT_BITS;
        for (int h = 0; h < HIDDEN_CNT; h++) acc[h] <= acc_nxt[h];
      end
      if (hid_load) hid_sr <= hid_nxt;
      else if (hid_en) hid_sr <= hid_sr >> 1;
      if (hid_en) begin
        for (int c = 0; c < CLASS_CNT; c++) score[c] <= score_nxt[c];
      end
    end
  end

  // A strict greater-than comparison keeps the lowest index when scores tie.
  always_comb begin
    best_idx   = '0;
    best_score = score[0];
    for (int c = 1; c < CLASS_CNT; c++) begin
      if (score[c] > best_score) begin
        best_score = score[c];
        best_idx   = PRED_W'(c);
      end
    end
  end

  assign prediction = best_idx;

endmodule

// File: tb/tb_har_tnn1_tnnzeq.sv
// Bench for har_tnn1_tnnzeq. Several differently weighted instances share the clock,
// reset and data, and each one is compared against a neuron-by-neuron arithmetic model.
module tb_har_tnn1_tnnzeq;

  localparam int FC  = 12;
  localparam int HC  = 40;
  localparam int FB  = 4;
  localparam int CC  = 6;
  localparam int W1B = 2*HC*FC;
  localparam int W2B = 2*CC*HC;
  localparam int DB  = FB*FC;
  localparam int STEPS = FC + HC;

  function automatic logic [W1B-1:0] gen_rand(input int seed);
    logic [W1B-1:0] w;
    int unsigned s;
    w = '0;
    s = seed;
    for (int i = 0; i < W1B/2; i++) begin
      s = s * 32'd1103515245 + 32'd12345;
      w[2*i +: 2] = s[17:16];
    end
    return w;
  endfunction

  function automatic logic [W1B-1:0] gen_neg_w1();
    logic [W1B-1:0] w;
    w = '0;
    for (int h = 0; h < HC; h++)
      for (int f = 0; f < FC; f++)
        w[2*(h*FC+f) +: 2] = (h == 0) ? 2'b11 : 2'b01;
    return w;
  endfunction

  function automatic logic [W2B-1:0] gen_w2_one(input int cls, input int hid, input logic [1:0] v);
    logic [W2B-1:0] w;
    w = '0;
    for (int c = 0; c < CC; c++)
      for (int h = 0; h < HC; h++)
        if ((cls < 0 || c == cls) && (hid < 0 || h == hid)) w[2*(c*HC+h) +: 2] = v;
    return w;
  endfunction

  localparam logic [W1B-1:0] W1_R    = gen_rand(11);
  localparam logic [W1B-1:0] R2_FULL = gen_rand(7);
  localparam logic [W2B-1:0] W2_R    = R2_FULL[W2B-1:0];
  localparam logic [W2B-1:0] W2_ROW3 = gen_w2_one(3, -1, 2'b01);
  localparam logic [W1B-1:0] W1_NEG  = gen_neg_w1();
  localparam logic [W2B-1:0] W2_NEG  = gen_w2_one(5, 0, 2'b11);
  localparam logic [W2B-1:0] W2_10   = gen_w2_one(-1, -1, 2'b10);

  logic clk;
  logic rst;
  logic [DB-1:0] data;
  logic [2:0] pred_rand, pred_row3, pred_zero, pred_neg, pred_w10;
  int checks = 0;
  int errors = 0;

  har_tnn1_tnnzeq #(.W1(W1_R), .W2(W2_R)) u_rand
    (.clk(clk), .rst(rst), .data(data), .prediction(pred_rand));
  har_tnn1_tnnzeq #(.W1('0), .W2(W2_ROW3)) u_row3
    (.clk(clk), .rst(rst), .data(data), .prediction(pred_row3));
  har_tnn1_tnnzeq #(.W1('0), .W2('0)) u_zero
    (.clk(clk), .rst(rst), .data(data), .prediction(pred_zero));
  har_tnn1_tnnzeq #(.W1(W1_NEG), .W2(W2_NEG)) u_neg
    (.clk(clk), .rst(rst), .data(data), .prediction(pred_neg));
  har_tnn1_tnnzeq #(.W1(W1_R), .W2(W2_10)) u_w10
    (.clk(clk), .rst(rst), .data(data), .prediction(pred_w10));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int wval(input logic [1:0] b);
    if (b == 2'b01) return 1;
    if (b == 2'b11) return -1;
    return 0;
  endfunction

  function automatic int model_pred(input logic [DB-1:0] d, input logic [W1B-1:0] w1,
                                    input logic [W2B-1:0] w2);
    int sc [CC];
    int acc, v, best;
    for (int c = 0; c < CC; c++) sc[c] = 0;
    for (int h = 0; h < HC; h++) begin
      acc = 0;
      for (int f = 0; f < FC; f++) acc += wval(w1[2*(h*FC+f) +: 2]) * int'(d[f*FB +: FB]);
      v = (acc >= 0) ? 1 : -1;
      for (int c = 0; c < CC; c++) sc[c] += wval(w2[2*(c*HC+h) +: 2]) * v;
    end
    best = 0;
    for (int c = 1; c < CC; c++) if (sc[c] > sc[best]) best = c;
    return best;
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [DB-1:0] d);
    check({tag, "_rand"}, int'(pred_rand), model_pred(d, W1_R, W2_R));
    check({tag, "_row3"}, int'(pred_row3), 3);
    check({tag, "_zero"}, int'(pred_zero), 0);
    check({tag, "_neg"},  int'(pred_neg),  model_pred(d, W1_NEG, W2_NEG));
    check({tag, "_w10"},  int'(pred_w10),  0);
  endtask

  task automatic start(input logic [DB-1:0] d);
    @(negedge clk);
    rst  = 1'b0;
    data = d;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run_steps(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [DB-1:0] rand_data();
    logic [DB-1:0] d;
    d[31:0]  = $urandom();
    d[DB-1:32] = 16'($urandom());
    return d;
  endfunction

  initial begin
    logic [DB-1:0] d1, d2;
    rst  = 1'b0;
    data = '0;
    @(posedge clk);
    @(negedge clk);
    check("reset_rand", int'(pred_rand), 0);
    check("reset_row3", int'(pred_row3), 0);
    check("reset_neg",  int'(pred_neg),  0);

    d1 = {DB{1'b1}};
    start(d1);
    run_steps(STEPS);
    check_all("all15", d1);
    check("neg_all15_is5", int'(pred_neg), 5);

    start('0);
    run_steps(STEPS);
    check_all("zeros", '0);
    check("neg_zero_is0", int'(pred_neg), 0);

    d1 = rand_data();
    start(d1);
    run_steps(STEPS);
    check_all("clean", d1);
    run_steps(25);
    check_all("hold", d1);

    d1 = rand_data();
    start(d1);
    run_steps(3);
    data = ~d1;
    run_steps(STEPS - 3);
    check_all("data_change", d1);

    d1 = rand_data();
    d2 = rand_data();
    start(d1);
    run_steps(20);
    start(d2);
    run_steps(STEPS);
    check_all("mid_reset", d2);

    for (int i = 0; i < 8; i++) begin
      d1 = rand_data();
      start(d1);
      run_steps(STEPS);
      check_all("random", d1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
